// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP synapse controller.
package stdp_pkg;

    typedef logic [7:0] weight_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRE_OPEN  = 2'd1,
        POST_OPEN = 2'd2,
        UPDATE    = 2'd3
    } stdp_state_t;

    localparam int unsigned DEF_CNT_W     = 4;
    localparam int unsigned DEF_WINDOW    = 15;
    localparam weight_t     DEF_W_INIT    = 8'd64;
    localparam weight_t     DEF_A_PLUS    = 8'd16;
    localparam weight_t     DEF_A_MINUS   = 8'd16;
    localparam int unsigned DEF_TAU_SHIFT = 2;

endpackage

// File: rtl/stdp_delta.sv
// Combinational weight update: shift-decayed amplitude applied with saturation.
module stdp_delta
    import stdp_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter weight_t     A_PLUS    = DEF_A_PLUS,
    parameter weight_t     A_MINUS   = DEF_A_MINUS,
    parameter int unsigned TAU_SHIFT = DEF_TAU_SHIFT
) (
    input  logic [7:0]       weight,
    input  logic [CNT_W-1:0] dt,
    input  logic             ltp_sel,
    output logic [7:0]       next_weight_c
);

    logic [31:0] shamt;
    weight_t     amp;
    weight_t     delta;
    logic [8:0]  sum9;
    logic [8:0]  diff9;

    // Amplitude halves every 2^TAU_SHIFT cycles of distance; vanishes past 8 halvings.
    always_comb begin
        shamt = 32'(dt) >> TAU_SHIFT;
        amp   = ltp_sel ? A_PLUS : A_MINUS;
        delta = (shamt >= 32'd8) ? 8'd0 : (amp >> shamt);
        sum9  = {1'b0, weight} + {1'b0, delta};
        diff9 = {1'b0, weight} - {1'b0, delta};
        if (ltp_sel) begin
            next_weight_c = sum9[8] ? 8'hFF : sum9[7:0];
        end else begin
            next_weight_c = diff9[8] ? 8'h00 : diff9[7:0];
        end
    end

endmodule

// File: rtl/stdp_ctrl.sv
// STDP controller: pairs pre/post spikes, updates the synaptic weight, drives syn current.
module stdp_ctrl
    import stdp_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter weight_t     W_INIT    = DEF_W_INIT,
    parameter weight_t     A_PLUS    = DEF_A_PLUS,
    parameter weight_t     A_MINUS   = DEF_A_MINUS,
    parameter int unsigned TAU_SHIFT = DEF_TAU_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             learn_en,
    input  logic             pre_spike,
    input  logic             post_spike,
    output logic [7:0]       weight,
    output logic [7:0]       syn_current,
    output logic [CNT_W-1:0] dt,
    output logic             ltp,
    output logic             ltd,
    output logic             busy
);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_PRE_OPEN  = PRE_OPEN;
    localparam logic [1:0] S_POST_OPEN = POST_OPEN;
    localparam logic [1:0] S_UPDATE    = UPDATE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pair_dt_q, pair_dt_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] dt_q, dt_d;
    weight_t          weight_q, weight_d;
    weight_t          syn_q, syn_d;
    logic             ltp_q, ltp_d;
    logic             ltd_q, ltd_d;
    logic             busy_q, busy_d;
    weight_t          next_weight_c;

    stdp_delta #(
        .CNT_W     (CNT_W),
        .A_PLUS    (A_PLUS),
        .A_MINUS   (A_MINUS),
        .TAU_SHIFT (TAU_SHIFT)
    ) u_delta (
        .weight        (weight_q),
        .dt            (pair_dt_q),
        .ltp_sel       (sel_q),
        .next_weight_c (next_weight_c)
    );

    // State and output registers; ena low stalls everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pair_dt_q <= '0;
            sel_q     <= 1'b0;
            dt_q      <= '0;
            weight_q  <= W_INIT;
            syn_q     <= '0;
            ltp_q     <= 1'b0;
            ltd_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pair_dt_q <= pair_dt_d;
            sel_q     <= sel_d;
            dt_q      <= dt_d;
            weight_q  <= weight_d;
            syn_q     <= syn_d;
            ltp_q     <= ltp_d;
            ltd_q     <= ltd_d;
            busy_q    <= busy_d;
        end
    end

    // Pairing FSM, window counter and weight update decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pair_dt_d = pair_dt_q;
        sel_d     = sel_q;
        dt_d      = dt_q;
        weight_d  = weight_q;
        ltp_d     = 1'b0;
        ltd_d     = 1'b0;
        syn_d     = pre_spike ? weight_q : 8'd0;

        case (state_q)
            S_IDLE: begin
                if (pre_spike && !post_spike) begin
                    state_d = S_PRE_OPEN;
                    cnt_d   = CNT_W'(1);
                end else if (post_spike && !pre_spike) begin
                    state_d = S_POST_OPEN;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_PRE_OPEN: begin
                if (post_spike) begin
                    pair_dt_d = cnt_q;
                    sel_d     = 1'b1;
                    state_d   = S_UPDATE;
                end else if (pre_spike) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q == CNT_W'(WINDOW)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_POST_OPEN: begin
                if (pre_spike) begin
                    pair_dt_d = cnt_q;
                    sel_d     = 1'b0;
                    state_d   = S_UPDATE;
                end else if (post_spike) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q == CNT_W'(WINDOW)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_UPDATE: begin
                weight_d = next_weight_c;
                dt_d     = pair_dt_q;
                ltp_d    = sel_q;
                ltd_d    = !sel_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Learning disabled: abandon any window and freeze the learning outputs.
        if (!learn_en) begin
            state_d  = S_IDLE;
            weight_d = weight_q;
            dt_d     = dt_q;
            ltp_d    = ltp_q;
            ltd_d    = ltd_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign weight      = weight_q;
    assign syn_current = syn_q;
    assign dt          = dt_q;
    assign ltp         = ltp_q;
    assign ltd         = ltd_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_stdp_ctrl.sv
// Directed bench for stdp_ctrl with default parameters.
module tb_stdp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       learn_en;
    logic       pre_spike;
    logic       post_spike;
    logic [7:0] weight;
    logic [7:0] syn_current;
    logic [3:0] dt;
    logic       ltp;
    logic       ltd;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    stdp_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .learn_en    (learn_en),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .weight      (weight),
        .syn_current (syn_current),
        .dt          (dt),
        .ltp         (ltp),
        .ltd         (ltd),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given spikes held across the edge; returns #1 after the edge.
    task automatic cyc(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        @(posedge clk);
        #1;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Pre then post d cycles later; returns when the update is visible.
    task automatic pair_ltp(input int d);
        cyc(1'b1, 1'b0);
        repeat (d - 1) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    // Post then pre d cycles later; returns when the update is visible.
    task automatic pair_ltd(input int d);
        cyc(1'b0, 1'b1);
        repeat (d - 1) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        ena      = 1'b1;
        learn_en = 1'b1;
        do_reset();

        // Reset state
        chk("rst_weight", weight, 64);
        chk("rst_syn", syn_current, 0);
        chk("rst_dt", dt, 0);
        chk("rst_ltp", ltp, 0);
        chk("rst_ltd", ltd, 0);
        chk("rst_busy", busy, 0);

        // LTP at dt=3
        cyc(1'b1, 1'b0);
        chk("ltp3_busy_open", busy, 1);
        chk("ltp3_syn_pre", syn_current, 64);
        cyc(1'b0, 1'b0);
        chk("ltp3_syn_drop", syn_current, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("ltp3_busy_upd", busy, 1);
        chk("ltp3_w_before", weight, 64);
        chk("ltp3_ltp_early", ltp, 0);
        cyc(1'b0, 1'b0);
        chk("ltp3_weight", weight, 80);
        chk("ltp3_dt", dt, 3);
        chk("ltp3_ltp", ltp, 1);
        chk("ltp3_ltd", ltd, 0);
        chk("ltp3_busy_done", busy, 0);
        cyc(1'b0, 1'b0);
        chk("ltp3_ltp_end", ltp, 0);

        // syn_current follows weight 80
        cyc(1'b1, 1'b1);
        chk("syn80", syn_current, 80);
        cyc(1'b0, 1'b0);
        chk("syn80_drop", syn_current, 0);

        // LTD at dt=5
        do_reset();
        pair_ltd(5);
        chk("ltd5_weight", weight, 56);
        chk("ltd5_dt", dt, 5);
        chk("ltd5_ltd", ltd, 1);
        chk("ltd5_ltp", ltp, 0);
        cyc(1'b0, 1'b0);
        chk("ltd5_ltd_end", ltd, 0);

        // Timeout: post 16 cycles after pre is not paired
        do_reset();
        cyc(1'b1, 1'b0);
        repeat (14) cyc(1'b0, 1'b0);
        chk("to_busy_cnt15", busy, 1);
        cyc(1'b0, 1'b0);
        chk("to_busy_drop", busy, 0);
        cyc(1'b0, 1'b1);
        chk("to_post_opens", busy, 1);
        chk("to_weight", weight, 64);
        chk("to_ltp", ltp, 0);
        repeat (15) cyc(1'b0, 1'b0);
        chk("to_post_closed", busy, 0);
        chk("to_weight2", weight, 64);
        chk("to_ltd", ltd, 0);

        // Upper saturation
        do_reset();
        repeat (11) pair_ltp(1);
        chk("sat_240", weight, 240);
        pair_ltp(4);
        pair_ltp(12);
        chk("sat_250", weight, 250);
        pair_ltp(1);
        chk("sat_255", weight, 255);
        chk("sat_255_ltp", ltp, 1);
        chk("sat_255_dt", dt, 1);

        // Lower saturation
        do_reset();
        repeat (3) pair_ltd(1);
        pair_ltd(4);
        pair_ltd(12);
        chk("sat_6", weight, 6);
        pair_ltd(1);
        chk("sat_0", weight, 0);
        chk("sat_0_ltd", ltd, 1);
        pair_ltd(1);
        chk("sat_0_again", weight, 0);
        chk("sat_0_again_ltd", ltd, 1);

        // Simultaneous spikes in IDLE
        do_reset();
        cyc(1'b1, 1'b1);
        chk("sim_busy", busy, 0);
        chk("sim_syn", syn_current, 64);
        cyc(1'b0, 1'b0);
        chk("sim_weight", weight, 64);
        chk("sim_ltp", ltp, 0);
        chk("sim_ltd", ltd, 0);

        // Nearest-neighbour restart
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("nn_dt", dt, 2);
        chk("nn_weight", weight, 80);
        chk("nn_ltp", ltp, 1);

        // Asynchronous reset while PRE_OPEN
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("ar_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_weight", weight, 64);
        chk("ar_busy", busy, 0);
        chk("ar_dt", dt, 0);
        chk("ar_ltp", ltp, 0);
        chk("ar_syn", syn_current, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1);
        chk("ar_window_gone_busy", busy, 1);
        cyc(1'b0, 1'b0);
        chk("ar_window_gone_ltp", ltp, 0);
        chk("ar_window_gone_w", weight, 64);

        // learn_en low during a pairing
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        learn_en = 1'b0;
        cyc(1'b0, 1'b1);
        chk("le_busy", busy, 0);
        cyc(1'b0, 1'b0);
        chk("le_weight", weight, 64);
        chk("le_ltp", ltp, 0);
        chk("le_dt", dt, 0);
        cyc(1'b1, 1'b0);
        chk("le_syn", syn_current, 64);
        chk("le_busy2", busy, 0);
        learn_en = 1'b1;
        cyc(1'b0, 1'b0);

        // ena low stalls counter and outputs; spikes while stalled are lost
        do_reset();
        cyc(1'b1, 1'b0);
        ena = 1'b0;
        cyc(1'b0, 1'b1);
        chk("en_syn_hold", syn_current, 64);
        chk("en_busy_hold", busy, 1);
        ena = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("en_dt", dt, 2);
        chk("en_weight", weight, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
